// File: rtl/car_pkg.sv
// car_pkg: shared constants, state encoding and lane direction lookup for
// the road-lane car controller.
package car_pkg;

  localparam int NUM_LANES = 5;

  // Frames between moves for each lane (lane 1 first).
  localparam logic [3:0] LANE_PERIOD [NUM_LANES] = '{4'd1, 4'd2, 4'd1, 4'd3, 4'd2};

  // Left-edge X of each car after reset (lane 1 first).
  localparam logic [9:0] LANE_INIT_X [NUM_LANES] = '{10'd0, 10'd160, 10'd320, 10'd480, 10'd96};

  // Direction pattern, read lane 1 first from the leftmost digit. Bit 0 is
  // the last digit and is shared by lanes 4 and 5.
  localparam logic [3:0] LANE_REVERSE = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_COMMIT = 2'd2
  } car_state_t;

  function automatic logic lane_is_reverse(input logic [2:0] lane);
    logic rev;
    case (lane)
      3'd0:    rev = LANE_REVERSE[3];
      3'd1:    rev = LANE_REVERSE[2];
      3'd2:    rev = LANE_REVERSE[1];
      default: rev = LANE_REVERSE[0];
    endcase
    return rev;
  endfunction

endpackage

// File: rtl/car_lane_step.sv
// car_lane_step: combinational next-X for one lane with wrap at the visible
// width. Forward lanes add the step, reverse lanes subtract it.
//   i_X        current left-edge X (0..H_VISIBLE_AREA-1)
//   i_Step     pixels to move (1..4)
//   i_Reverse  1 = move toward decreasing X
//   o_Nx       wrapped next X
module car_lane_step #(
  parameter int H_VISIBLE_AREA = 640
) (
  input  logic [9:0] i_X,
  input  logic [2:0] i_Step,
  input  logic       i_Reverse,
  output logic [9:0] o_Nx
);

  localparam logic [10:0] H_WRAP = 11'(H_VISIBLE_AREA);

  logic [10:0] x_ext;
  logic [10:0] step_ext;
  logic [10:0] fwd_sum;
  logic [10:0] nx_ext;
  logic        unused_nx_msb;

  always_comb begin
    x_ext    = {1'b0, i_X};
    step_ext = {8'd0, i_Step};
    fwd_sum  = x_ext + step_ext;
    nx_ext   = fwd_sum;
    if (i_Reverse) begin
      if (x_ext < step_ext) begin
        nx_ext = x_ext + H_WRAP - step_ext;
      end else begin
        nx_ext = x_ext - step_ext;
      end
    end else if (fwd_sum >= H_WRAP) begin
      nx_ext = fwd_sum - H_WRAP;
    end
  end

  // Results are always below H_WRAP, so the top bit is always zero.
  assign unused_nx_msb = nx_ext[10];
  assign o_Nx          = nx_ext[9:0];

endmodule

// File: rtl/car_lane_controller.sv
// car_lane_controller: once per frame, steps the five road-lane cars into
// shadow registers one lane per cycle, then commits all positions at once
// so the sprite stage never sees a half-updated frame.
//   i_Clk, i_Reset         pixel clock, synchronous active-high reset
//   i_Frame_Tick           start-of-blanking pulse, starts an update
//   i_Pause                freezes motion and dividers while high
//   i_Level                difficulty 0..3 (step = 1 + level when enabled)
//   o_Car_1X..5X_Position  committed car X positions
//   o_Reverse              lane direction pattern
//   o_Update_Done          one-cycle pulse after commit
//   o_Busy                 update in progress
// Build option: CAR_SPEEDUP_EN makes the step depend on i_Level; without it
// every move is 1 pixel and i_Level is ignored.
//
// state     | meaning
// ST_IDLE   | waiting for an unpaused frame tick
// ST_UPDATE | stepping lane lane_idx_q into the shadow registers
// ST_COMMIT | copying the shadow to the outputs, pulsing done
module car_lane_controller
  import car_pkg::*;
#(
  parameter int H_VISIBLE_AREA = 640,
  parameter int TILE_SIZE      = 32
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Frame_Tick,
  input  logic       i_Pause,
  input  logic [1:0] i_Level,
  output logic [9:0] o_Car_1X_Position,
  output logic [9:0] o_Car_2X_Position,
  output logic [9:0] o_Car_3X_Position,
  output logic [9:0] o_Car_4X_Position,
  output logic [9:0] o_Car_5X_Position,
  output logic [3:0] o_Reverse,
  output logic       o_Update_Done,
  output logic       o_Busy
);

  // Sprite width is informational only; wrap uses the visible width.
  localparam int unused_tile_size = TILE_SIZE;

  car_state_t state_q;
  car_state_t state_d;

  logic [2:0] lane_idx_q;
  logic [2:0] step_q;
  logic [2:0] step_sel;
  logic [9:0] shadow_x_q [NUM_LANES];
  logic [9:0] pos_q      [NUM_LANES];
  logic [3:0] div_cnt_q  [NUM_LANES];
  logic       done_q;

  logic       start_update;
  logic       last_lane;
  logic       lane_hit;
  logic [9:0] cur_x;
  logic       cur_rev;
  logic [9:0] next_x;

`ifdef CAR_SPEEDUP_EN
  assign step_sel = {1'b0, i_Level} + 3'd1;
`else
  logic unused_level;
  assign unused_level = ^i_Level;
  assign step_sel     = 3'd1;
`endif

  assign cur_x   = shadow_x_q[lane_idx_q];
  assign cur_rev = lane_is_reverse(lane_idx_q);

  car_lane_step #(
    .H_VISIBLE_AREA (H_VISIBLE_AREA)
  ) u_step (
    .i_X       (cur_x),
    .i_Step    (step_q),
    .i_Reverse (cur_rev),
    .o_Nx      (next_x)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    start_update = 1'b0;
    last_lane    = (lane_idx_q == 3'(NUM_LANES - 1));
    lane_hit     = (div_cnt_q[lane_idx_q] == (LANE_PERIOD[lane_idx_q] - 4'd1));
    case (state_q)
      ST_IDLE: begin
        if (i_Frame_Tick && !i_Pause) begin
          start_update = 1'b1;
          state_d      = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (last_lane) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      lane_idx_q <= 3'd0;
      step_q     <= 3'd1;
      done_q     <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        shadow_x_q[k] <= LANE_INIT_X[k];
        pos_q[k]      <= LANE_INIT_X[k];
        div_cnt_q[k]  <= 4'd0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_update) begin
            lane_idx_q <= 3'd0;
            step_q     <= step_sel;
          end
        end
        ST_UPDATE: begin
          if (lane_hit) begin
            shadow_x_q[lane_idx_q] <= next_x;
            div_cnt_q[lane_idx_q]  <= 4'd0;
          end else begin
            div_cnt_q[lane_idx_q]  <= div_cnt_q[lane_idx_q] + 4'd1;
          end
          lane_idx_q <= lane_idx_q + 3'd1;
        end
        ST_COMMIT: begin
          for (int k = 0; k < NUM_LANES; k++) begin
            pos_q[k] <= shadow_x_q[k];
          end
          done_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_Car_1X_Position = pos_q[0];
  assign o_Car_2X_Position = pos_q[1];
  assign o_Car_3X_Position = pos_q[2];
  assign o_Car_4X_Position = pos_q[3];
  assign o_Car_5X_Position = pos_q[4];
  assign o_Reverse         = LANE_REVERSE;
  assign o_Update_Done     = done_q;
  assign o_Busy            = (state_q != ST_IDLE);

endmodule
